// File: rtl/adpcm_pkg.sv
// Shared ADPCM definitions: step table, index adjustments, common types and
// the index clamp used by both the decoder and the encoder-side step tracker.
package adpcm_pkg;

  typedef logic signed [15:0] pcm_t;
  typedef logic [3:0]         code_t;
  typedef logic [6:0]         step_idx_t;
  typedef logic [15:0]        step_t;
  // Five bits so that the +8 adjustment is representable as a signed value.
  typedef logic signed [4:0]  idx_adj_t;

  localparam int        STEP_COUNT     = 89;
  localparam step_idx_t MAX_STEP_INDEX = 7'd88;

  // Standard IMA step-size table.
  localparam step_t STEP_TABLE [STEP_COUNT] = '{
    16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
    16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
    16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
    16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
    16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
    16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
    16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
    16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
    16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
    16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
    16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
    16'd32767
  };

  // Index adjustment per code magnitude: small codes shrink the step,
  // large codes grow it quickly so the predictor can follow steep slopes.
  localparam idx_adj_t INDEX_ADJ [8] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

  // Clamp a widened, signed index back into [0, max_idx].
  function automatic step_idx_t clamp_index(input logic signed [8:0] raw,
                                            input step_idx_t         max_idx);
    step_idx_t result;
    if (raw < 9'sd0) begin
      result = '0;
    end else if (raw > $signed({2'b00, max_idx})) begin
      result = max_idx;
    end else begin
      result = raw[6:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/adpcm_step_rom.sv
// Combinational step-size lookup, shared between decoder and encoder tracker.
module adpcm_step_rom
  import adpcm_pkg::*;
(
  input  step_idx_t idx,
  output step_t     step
);

  // Out-of-range indices fall back to the largest step rather than reading
  // past the end of the table.
  always_comb begin
    step = STEP_TABLE[MAX_STEP_INDEX];
    if (idx <= MAX_STEP_INDEX) begin
      step = STEP_TABLE[idx];
    end
  end

endmodule

// File: rtl/adpcm_decoder.sv
// Streaming IMA ADPCM decoder: 4-bit codes in, saturated 16-bit PCM out, with
// valid/ready on both sides and a header port that reseeds predictor and index.
module adpcm_decoder
  import adpcm_pkg::*;
#(
  parameter int NUM_STEPS = 89
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_valid,
  input  logic [15:0] init_sample,
  input  logic [6:0]  init_index,
  input  logic        code_valid,
  input  logic [3:0]  code,
  output logic        code_ready,
  output logic        sample_valid,
  output logic [15:0] sample,
  input  logic        sample_ready
);

  localparam step_idx_t MAX_IDX = step_idx_t'(NUM_STEPS - 1);

  pcm_t               pred;
  step_idx_t          idx;
  step_t              step;
  logic [16:0]        diff;
  logic signed [17:0] sum_wide;
  pcm_t               new_sample;
  logic signed [8:0]  idx_raw;
  step_idx_t          idx_next;
  step_idx_t          init_idx_clamped;
  logic               accept;

  adpcm_step_rom u_step_rom (
    .idx  (idx),
    .step (step)
  );

  // A header cycle blocks codes; otherwise accept when the output slot is free
  // or is being drained on this same edge.
  assign code_ready = !init_valid && (!sample_valid || sample_ready);
  assign accept     = code_valid && code_ready;

  // Dequantize the code magnitude into an unsigned difference.
  always_comb begin
    diff = {4'b0000, step[15:3]};
    if (code[2]) diff = diff + {1'b0, step};
    if (code[1]) diff = diff + {2'b00, step[15:1]};
    if (code[0]) diff = diff + {3'b000, step[15:2]};
  end

  // Apply the difference to the predictor and saturate to 16-bit PCM.
  always_comb begin
    if (code[3]) begin
      sum_wide = {{2{pred[15]}}, pred} - $signed({1'b0, diff});
    end else begin
      sum_wide = {{2{pred[15]}}, pred} + $signed({1'b0, diff});
    end
    if (sum_wide > 18'sd32767) begin
      new_sample = 16'sh7FFF;
    end else if (sum_wide < -18'sd32768) begin
      new_sample = 16'sh8000;
    end else begin
      new_sample = sum_wide[15:0];
    end
  end

  // Step-index adaptation and header seed clamping.
  always_comb begin
    idx_raw          = $signed({2'b00, idx}) +
                       $signed({{4{INDEX_ADJ[code[2:0]][4]}}, INDEX_ADJ[code[2:0]]});
    idx_next         = clamp_index(idx_raw, MAX_IDX);
    init_idx_clamped = (init_index > MAX_IDX) ? MAX_IDX : init_index;
  end

  // Predictor and index state: header seeds take priority over codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred <= '0;
      idx  <= '0;
    end else if (init_valid) begin
      pred <= init_sample;
      idx  <= init_idx_clamped;
    end else if (accept) begin
      pred <= new_sample;
      idx  <= idx_next;
    end
  end

  // Output register: load on accept, hold under backpressure, clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else if (accept) begin
      sample       <= new_sample;
      sample_valid <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adpcm_decoder.sv
// Self-checking bench for adpcm_decoder: directed corner cases, a sine
// loopback through a behavioural quantizer, and randomized traffic, all
// compared against an integer reference model of the decoder.
module tb_adpcm_decoder;

  logic        clk;
  logic        rst_n;
  logic        init_valid;
  logic [15:0] init_sample;
  logic [6:0]  init_index;
  logic        code_valid;
  logic [3:0]  code;
  logic        code_ready;
  logic        sample_valid;
  logic [15:0] sample;
  logic        sample_ready;

  int checks;
  int fails;

  // Reference model state.
  int m_pred;
  int m_idx;
  int m_sample;
  int m_valid;

  int step_tab [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };
  int adj_tab [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  adpcm_decoder #(.NUM_STEPS(89)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_valid   (init_valid),
    .init_sample  (init_sample),
    .init_index   (init_index),
    .code_valid   (code_valid),
    .code         (code),
    .code_ready   (code_ready),
    .sample_valid (sample_valid),
    .sample       (sample),
    .sample_ready (sample_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dut_sample();
    return int'($signed(sample));
  endfunction

  function automatic int clip(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Decode one code in the model from the arithmetic rules.
  task automatic modelDecode(input int c);
    int step;
    int diff;
    int nv;
    step = step_tab[m_idx];
    diff = step / 8;
    if ((c & 4) != 0) diff += step;
    if ((c & 2) != 0) diff += step / 2;
    if ((c & 1) != 0) diff += step / 4;
    nv       = ((c & 8) != 0) ? m_pred - diff : m_pred + diff;
    nv       = clip(nv, -32768, 32767);
    m_pred   = nv;
    m_sample = nv;
    m_valid  = 1;
    m_idx    = clip(m_idx + adj_tab[c & 7], 0, 88);
  endtask

  // Behavioural quantizer tracking the same model state as the decoder.
  function automatic int encodeSample(input int x);
    int step;
    int d;
    int c;
    step = step_tab[m_idx];
    d    = x - m_pred;
    c    = 0;
    if (d < 0) begin
      c = 8;
      d = -d;
    end
    if (d >= step) begin
      c |= 4;
      d -= step;
    end
    if (d >= step / 2) begin
      c |= 2;
      d -= step / 2;
    end
    if (d >= step / 4) c |= 1;
    return c;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check ready, let the
  // rising edge happen, advance the model, then check the output register.
  task automatic applyStimulus(input bit iv, input int isamp, input int iidx,
                               input bit cv, input int c, input bit sr);
    int exp_ready;
    init_valid   = iv;
    init_sample  = isamp[15:0];
    init_index   = iidx[6:0];
    code_valid   = cv;
    code         = c[3:0];
    sample_ready = sr;
    #1;
    exp_ready = (!iv && (m_valid == 0 || sr)) ? 1 : 0;
    checkOutput("code_ready", int'(code_ready), exp_ready);
    @(posedge clk);
    if (iv) begin
      m_pred = clip(isamp, -32768, 32767);
      m_idx  = clip(iidx & 127, 0, 88);
    end
    if (!iv && cv && exp_ready == 1) begin
      modelDecode(c);
    end else if (m_valid == 1 && sr) begin
      m_valid = 0;
    end
    @(negedge clk);
    checkOutput("sample_valid", int'(sample_valid), m_valid);
    checkOutput("sample", dut_sample(), m_sample);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n        = 1'b0;
    init_valid   = 1'b0;
    code_valid   = 1'b0;
    sample_ready = 1'b0;
    m_pred = 0; m_idx = 0; m_sample = 0; m_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int held;
    int x;
    int c;
    int err;
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    init_valid = 1'b0; init_sample = '0; init_index = '0;
    code_valid = 1'b0; code = '0; sample_ready = 1'b0;

    $display("[TB] reset state");
    doReset();
    #1;
    checkOutput("reset_sample_valid", int'(sample_valid), 0);
    checkOutput("reset_sample", dut_sample(), 0);
    checkOutput("reset_code_ready", int'(code_ready), 1);
    @(negedge clk);

    $display("[TB] basic and negative decode");
    applyStimulus(0, 0, 0, 1, 4'h4, 1);
    checkOutput("basic_sample", dut_sample(), 7);
    applyStimulus(0, 0, 0, 1, 4'hF, 1);
    checkOutput("negative_sample", dut_sample(), -9);
    applyStimulus(0, 0, 0, 1, 4'h4, 1);
    checkOutput("index_after_negative", dut_sample(), 12);

    $display("[TB] upper clamp and saturation");
    applyStimulus(1, 32767, 88, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 4'h7, 1);
    checkOutput("sat_high", dut_sample(), 32767);
    applyStimulus(1, -32768, 120, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 4'hF, 1);
    checkOutput("sat_low", dut_sample(), -32768);
    applyStimulus(0, 0, 0, 1, 4'h4, 1);
    checkOutput("index_held_at_max", dut_sample(), 4094);

    $display("[TB] lower clamp");
    doReset();
    applyStimulus(0, 0, 0, 1, 4'h1, 1);
    checkOutput("low_code1_sample", dut_sample(), 1);
    applyStimulus(0, 0, 0, 1, 4'h4, 1);
    checkOutput("index_held_at_zero", dut_sample(), 8);

    $display("[TB] backpressure and init priority");
    applyStimulus(0, 0, 0, 1, 4'h5, 0);
    held = dut_sample();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 4'h6, 0);
      checkOutput("stall_stable", dut_sample(), held);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, i + 2, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 100, 30, 1, 4'h5, 1);
    applyStimulus(0, 0, 0, 1, 4'h5, 1);

    $display("[TB] mid-stream reset");
    applyStimulus(0, 0, 0, 1, 4'h6, 1);
    applyStimulus(0, 0, 0, 1, 4'h3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", int'(sample_valid), 0);
    checkOutput("async_rst_sample", dut_sample(), 0);
    m_pred = 0; m_idx = 0; m_sample = 0; m_valid = 0;
    code_valid = 1'b1; code = 4'h7; sample_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_code_ignored", int'(sample_valid), 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 1, 4'h4, 1);
    checkOutput("restart_sample", dut_sample(), 7);

    $display("[TB] sine loopback");
    applyStimulus(1, 0, 20, 0, 0, 1);
    for (int n = 0; n < 144; n++) begin
      x = $rtoi($floor(4000.0 * $sin(2.0 * 3.14159265358979 * 1000.0 * n / 48000.0) + 0.5));
      c = encodeSample(x);
      applyStimulus(0, 0, 0, 1, c, 1);
      if (n >= 16) begin
        err = x - dut_sample();
        if (err < 0) err = -err;
        checkOutput("sine_error_within_step", (err <= step_tab[m_idx]) ? 1 : 0, 1);
      end
    end

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 15) == 0),
                    int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 127)),
                    ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
